// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: state codes, handshake
// levels and the register-bus widths used by the HI/LO datapath.
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 2 * RegBus;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider; result is {remainder, quotient}
// for the HI/LO pair, held under a start/ready handshake until consumed.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = RegBus,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor;
  logic             signed_q;
  logic             sign1_q;
  logic             sign2_q;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH:0]   diff;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];

  // Trial subtract on the shifted partial remainder; diff[WIDTH] is the borrow.
  assign diff = {rem, dvd[WIDTH-1]} - {1'b0, divisor};

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      divisor  <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              dvd      <= op1_neg ? -opdata1_i : opdata1_i;
              divisor  <= op2_neg ? -opdata2_i : opdata2_i;
              rem      <= '0;
              cnt      <= '0;
              signed_q <= signed_div_i;
              sign1_q  <= opdata1_i[WIDTH-1];
              sign2_q  <= opdata2_i[WIDTH-1];
              state    <= DivOn;
            end
          end
        end

        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            rem      <= '0;
            dvd      <= '0;
            result_o <= '0;
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end
        end

        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else if (cnt != CNT_W'(WIDTH)) begin
            rem <= diff[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : diff[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + 1'b1;
          end else begin
            // Quotient is negative on differing signs; remainder follows the dividend.
            result_o <= {(signed_q && sign1_q) ? -rem : rem,
                         (signed_q && (sign1_q ^ sign2_q)) ? -dvd : dvd};
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
            cnt      <= '0;
          end else begin
            ready_o <= DivResultReady;
          end
        end

        default: state <= DivFree;
      endcase
    end
  end

endmodule : div_unit
